block_checker_stack: RTL and testbench
======================================

# block_checker_stack

Parametrised successor to the single-pair block checker. Consumes an ASCII byte stream one character per accepted cycle, splits it into space-delimited words, and recognises `begin`/`end` keywords case-insensitively; `fork`/`join` are also recognised when compiled in. Tracks nesting on a bounded type stack and reports:

- balance,
- current depth,
- a sticky error class.

Sits at the end of the character-stream front end as a structural lint stage.

## Interface
Parameters:
- `MAX_DEPTH`, default 8: stack entries; legal range 2..64.
- `DEPTH_W`, default `$clog2(MAX_DEPTH+1)`: width of `depth`. Derived; never overridden.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `in` in 8: ASCII character.
- `in_valid` in 1: `in` is sampled only when high.
- `result` out 1: 1 = all opened blocks closed and no error.
- `depth` out DEPTH_W: current open-block count.
- `error` out 1: sticky; set on the first structural fault.
- `err_code` out 2: 0 NONE, 1 UNDERFLOW, 2 MISMATCH, 3 OVERFLOW. Holds the first fault only.

## Operation
- A word is a maximal run of non-space bytes. A delimiter is 8'h20 only; no other byte delimits.
- Bytes in `A`–`Z` fold to lowercase before comparison. Any other non-space byte (digits, punctuation) is part of the word.
- Matcher state per word:
  - 3-bit length counter, saturating at 7.
  - One "still matching" flag per keyword.
  - A flag clears on a char mismatch or when length exceeds the keyword length.
- At a delimiter, a keyword fires if its flag is set and the length equals the keyword length exactly. Matcher state then clears.
  - Consecutive spaces form empty words; nothing fires.
  - A trailing word without a following space never fires.
- Events:
  - OPEN (`begin`/`fork`): push type (0 = begin, 1 = fork).
    - If depth == MAX_DEPTH: OVERFLOW, no push.
  - CLOSE (`end`/`join`):
    - If depth == 0: UNDERFLOW.
    - Else if the top type differs from the close type: MISMATCH.
    - Else pop.
- Once `error` = 1:
  - The stack and depth freeze.
  - The matcher keeps running but its events are discarded.
  - `result` = 0 until `reset`.
- `result` = (depth == 0) && !error.
- State machine (checker), states `IDLE_BAL`, `OPEN`, `ERR`:
  - `IDLE_BAL` → `OPEN` on a push.
  - `OPEN` → `IDLE_BAL` when a pop reaches depth 0.
  - Any state → `ERR` on a fault.
  - `ERR` is absorbing until reset.

## Timing
- Reset values: `result` = 1, `depth` = 0, `error` = 0, `err_code` = 0. The matcher is cleared and the stack pointer is 0; stack contents are don't-care.
- All outputs are registered. A delimiter sampled at edge N updates `result`, `depth` and `error` visibly after edge N. Latency is 1 cycle from the space byte.
- Cycles with `in_valid` = 0 leave all state unchanged and may occur mid-word.
- Reset mid-word discards the partial word. The next accepted byte starts a fresh word.
- Reset and `in_valid` asserted in the same cycle: reset wins and the byte is dropped.
- At most one event per accepted byte, so push and pop never coincide.

## Configuration
- Macro `BC_FORK_JOIN_EN`.
- Defined:
  - `fork`/`join` are recognised.
  - The stack stores a 1-bit type per entry.
  - MISMATCH is reachable.
- Undefined:
  - Only `begin`/`end` are recognised; `fork`/`join` are ordinary words.
  - The stack degenerates to a DEPTH_W counter with no storage.
  - `err_code` never reports 2.

## Structure
- Package `bc_pkg`:
  - `err_code` localparams (`BC_ERR_NONE`, `BC_ERR_UNDERFLOW`, `BC_ERR_MISMATCH`, `BC_ERR_OVERFLOW`).
  - Keyword byte constants and lengths.
  - Block type enum (`BC_T_BEGIN`, `BC_T_FORK`).
  - Event enum (`BC_EV_NONE`, `BC_EV_OPEN`, `BC_EV_CLOSE`).
- Sub-module `bc_word_matcher`: case fold, length counter and per-keyword flags. It emits a one-cycle `ev_valid`, `ev_kind` and `ev_type` on the delimiter cycle. The top level holds the stack and the checker FSM.

## Test plan
- `begin begin end end ` (MAX_DEPTH = 8) → depth after each space 1, 2, 1, 0; `result` 0, 0, 0, 1; `error` stays 0.
- `BeGiN EnD ` → `result` = 1 after the final space. `beginx end ` → UNDERFLOW (`err_code` 1) at the second space; `result` = 0 thereafter, even after `begin ` follows.
- With `BC_FORK_JOIN_EN`: `fork begin join ` → MISMATCH (`err_code` 2) at the third space; depth frozen at 2. Without the macro, the same stream gives depth 1, `error` 0.
- MAX_DEPTH = 4, five `begin ` words → `err_code` 3 at the fifth space; depth stays 4; `result` = 0.
- `begin` (no trailing space), with `in_valid` toggling 1/0 each cycle → depth 0, `result` 1. Then `reset` mid-word `be`, then `end ` → UNDERFLOW, proving the partial word was discarded.
- Double spaces `begin  end ` → depth 1 then 0; `result` = 1; no spurious events.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared constants for the block checker: error codes, keyword table, block and event types.
// Keywords fork/join are part of the active table only when BC_FORK_JOIN_EN is defined.
package bc_pkg;

  localparam logic [1:0] BC_ERR_NONE      = 2'd0;
  localparam logic [1:0] BC_ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] BC_ERR_MISMATCH  = 2'd2;
  localparam logic [1:0] BC_ERR_OVERFLOW  = 2'd3;

  typedef enum logic {
    BC_T_BEGIN = 1'b0,
    BC_T_FORK  = 1'b1
  } bc_type_e;

  typedef enum logic [1:0] {
    BC_EV_NONE  = 2'd0,
    BC_EV_OPEN  = 2'd1,
    BC_EV_CLOSE = 2'd2
  } bc_event_e;

  // Keyword text is right-aligned: the first character sits in the highest used byte.
  localparam int BC_KW_MAX = 4;
  localparam logic [39:0] BC_KW_TEXT [BC_KW_MAX] = '{
    "begin", {16'd0, "end"}, {8'd0, "fork"}, {8'd0, "join"}
  };
  localparam int        BC_KW_LEN  [BC_KW_MAX] = '{5, 3, 4, 4};
  localparam bc_event_e BC_KW_EV   [BC_KW_MAX] = '{BC_EV_OPEN, BC_EV_CLOSE, BC_EV_OPEN, BC_EV_CLOSE};
  localparam bc_type_e  BC_KW_TYPE [BC_KW_MAX] = '{BC_T_BEGIN, BC_T_BEGIN, BC_T_FORK, BC_T_FORK};

`ifdef BC_FORK_JOIN_EN
  localparam int BC_NUM_KW = 4;
`else
  localparam int BC_NUM_KW = 2;
`endif

  function automatic logic [7:0] bc_kw_byte(input int kw, input logic [2:0] idx);
    logic [39:0] text;
    int          len;
    text = BC_KW_TEXT[kw];
    len  = BC_KW_LEN[kw];
    if (int'(idx) >= len) return 8'h00;
    return text[8*(len-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/bc_word_matcher.sv
// Splits the byte stream into space-delimited words and flags keyword hits on the delimiter cycle.
// Event outputs are combinational from the delimiter byte; ev_type exists only with BC_FORK_JOIN_EN.
module bc_word_matcher
  import bc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic       ev_valid,
`ifdef BC_FORK_JOIN_EN
  output bc_type_e   ev_type,
`endif
  output bc_event_e  ev_kind
);

  logic [2:0]           len_reg;
  logic [BC_NUM_KW-1:0] match_reg;
  logic [BC_NUM_KW-1:0] char_hit;
  logic [BC_NUM_KW-1:0] fire;
  logic [7:0]           char_lc;
  logic                 is_space;

  assign is_space = (in == 8'h20);
  assign char_lc  = (in >= 8'h41 && in <= 8'h5A) ? (in + 8'h20) : in;

  for (genvar gi = 0; gi < BC_NUM_KW; gi++) begin : g_kw
    assign char_hit[gi] = (len_reg < 3'(BC_KW_LEN[gi])) && (char_lc == bc_kw_byte(gi, len_reg));
    assign fire[gi]     = in_valid && is_space && match_reg[gi] && (len_reg == 3'(BC_KW_LEN[gi]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_reg   <= 3'd0;
      match_reg <= '1;
    end else if (in_valid) begin
      if (is_space) begin
        len_reg   <= 3'd0;
        match_reg <= '1;
      end else begin
        len_reg   <= (len_reg == 3'd7) ? 3'd7 : len_reg + 3'd1;
        match_reg <= match_reg & char_hit;
      end
    end
  end

  // Keyword texts are distinct, so at most one bit of fire is ever set.
  always_comb begin
    ev_valid = 1'b0;
    ev_kind  = BC_EV_NONE;
`ifdef BC_FORK_JOIN_EN
    ev_type  = BC_T_BEGIN;
`endif
    for (int k = 0; k < BC_NUM_KW; k++) begin
      if (fire[k]) begin
        ev_valid = 1'b1;
        ev_kind  = BC_KW_EV[k];
`ifdef BC_FORK_JOIN_EN
        ev_type  = BC_KW_TYPE[k];
`endif
      end
    end
  end

endmodule

// File: rtl/block_checker_stack.sv
// Structural lint stage: tracks begin/end (and fork/join with BC_FORK_JOIN_EN) nesting on a
// bounded type stack and reports balance, depth and the first structural fault.
module block_checker_stack
  import bc_pkg::*;
#(
  parameter int MAX_DEPTH = 8,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               error,
  output logic [1:0]         err_code
);

  typedef enum logic [1:0] {IDLE_BAL, OPEN, ERR} state_e;

  state_e             state_reg, state_next;
  logic [DEPTH_W-1:0] depth_reg, depth_next;
  logic [1:0]         err_code_reg, err_code_next;
  logic               result_reg, error_reg;
  logic               push;
  logic               ev_valid;
  bc_event_e          ev_kind;

`ifdef BC_FORK_JOIN_EN
  localparam int IDX_W = $clog2(MAX_DEPTH);
  bc_type_e   ev_type;
  bc_type_e   stack_reg [MAX_DEPTH];
  logic [IDX_W-1:0] top_idx;
  assign top_idx = IDX_W'(depth_reg - 1'b1);
`endif

  bc_word_matcher u_matcher (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_valid (in_valid),
    .ev_valid (ev_valid),
`ifdef BC_FORK_JOIN_EN
    .ev_type  (ev_type),
`endif
    .ev_kind  (ev_kind)
  );

  always_comb begin
    state_next    = state_reg;
    depth_next    = depth_reg;
    err_code_next = err_code_reg;
    push          = 1'b0;
    if (state_reg != ERR && ev_valid) begin
      if (ev_kind == BC_EV_OPEN) begin
        if (depth_reg == DEPTH_W'(MAX_DEPTH)) begin
          state_next    = ERR;
          err_code_next = BC_ERR_OVERFLOW;
        end else begin
          push       = 1'b1;
          depth_next = depth_reg + 1'b1;
          state_next = OPEN;
        end
      end else if (ev_kind == BC_EV_CLOSE) begin
        if (depth_reg == '0) begin
          state_next    = ERR;
          err_code_next = BC_ERR_UNDERFLOW;
`ifdef BC_FORK_JOIN_EN
        end else if (stack_reg[top_idx] != ev_type) begin
          state_next    = ERR;
          err_code_next = BC_ERR_MISMATCH;
`endif
        end else begin
          depth_next = depth_reg - 1'b1;
          if (depth_reg == DEPTH_W'(1)) state_next = IDLE_BAL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE_BAL;
      depth_reg    <= '0;
      err_code_reg <= BC_ERR_NONE;
      result_reg   <= 1'b1;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      depth_reg    <= depth_next;
      err_code_reg <= err_code_next;
      result_reg   <= (depth_next == '0) && (state_next != ERR);
      error_reg    <= (state_next == ERR);
    end
  end

`ifdef BC_FORK_JOIN_EN
  // Contents are don't-care after reset; only the pointer (depth) is cleared.
  always_ff @(posedge clk) begin
    if (!reset && push) stack_reg[IDX_W'(depth_reg)] <= ev_type;
  end
`else
  logic unused_push;
  assign unused_push = push;
`endif

  assign result   = result_reg;
  assign depth    = depth_reg;
  assign error    = error_reg;
  assign err_code = err_code_reg;

endmodule

// File: tb/tb_block_checker_stack.sv
// Directed bench for block_checker_stack (MAX_DEPTH = 4); expectations are queued per delimiter
// and checked one cycle after each space is accepted.
module tb_block_checker_stack;

  localparam int TB_MAX = 4;
  localparam int TB_DW  = $clog2(TB_MAX + 1);

  typedef struct {
    string            tag;
    logic [TB_DW-1:0] depth;
    logic             result;
    logic             error;
    logic [1:0]       code;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             result;
  logic [TB_DW-1:0] depth;
  logic             error;
  logic [1:0]       err_code;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  block_checker_stack #(.MAX_DEPTH(TB_MAX)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in_byte),
    .in_valid (in_valid),
    .result   (result),
    .depth    (depth),
    .error    (error),
    .err_code (err_code)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(string tag, int d, bit r, bit e, int c);
    exp_t x;
    x.tag = tag; x.depth = TB_DW'(d); x.result = r; x.error = e; x.code = 2'(c);
    sb.push_back(x);
  endtask

  task automatic check_front();
    exp_t x;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty got=0 entries exp>=1");
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      checks++;
      assert (depth === x.depth) else begin
        failures++; $error("FAIL %s depth got=%0d exp=%0d", x.tag, depth, x.depth);
      end
      checks++;
      assert (result === x.result) else begin
        failures++; $error("FAIL %s result got=%0b exp=%0b", x.tag, result, x.result);
      end
      checks++;
      assert (error === x.error) else begin
        failures++; $error("FAIL %s error got=%0b exp=%0b", x.tag, error, x.error);
      end
      checks++;
      assert (err_code === x.code) else begin
        failures++; $error("FAIL %s err_code got=%0d exp=%0d", x.tag, err_code, x.code);
      end
      $display("txn %s depth=%0d result=%0b error=%0b err_code=%0d", x.tag, depth, result, error, err_code);
    end
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) begin
      in_byte  = s[i];
      in_valid = 1'b1;
      step();
      if (s[i] == 8'h20) check_front();
    end
    in_valid = 1'b0;
  endtask

  task automatic word(string tag, string s, int d, bit r, bit e, int c);
    expect_state(tag, d, r, e, c);
    send_str(s);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    string tail;
    tail = "begin";
    do_reset();
    expect_state("reset", 0, 1, 0, 0);
    check_front();

    word("nest_b1", "begin ", 1, 0, 0, 0);
    word("nest_b2", "begin ", 2, 0, 0, 0);
    word("nest_e1", "end ",   1, 0, 0, 0);
    word("nest_e2", "end ",   0, 1, 0, 0);

    do_reset();
    word("case_b", "BeGiN ", 1, 0, 0, 0);
    word("case_e", "EnD ",   0, 1, 0, 0);

    do_reset();
    word("beginx",   "beginx ", 0, 1, 0, 0);
    word("underflow", "end ",   0, 0, 1, 1);
    word("frozen_b",  "begin ", 0, 0, 1, 1);

    do_reset();
`ifdef BC_FORK_JOIN_EN
    word("fj_fork",  "fork ",  1, 0, 0, 0);
    word("fj_begin", "begin ", 2, 0, 0, 0);
    word("fj_join",  "join ",  2, 0, 1, 2);
`else
    word("fj_fork",  "fork ",  0, 1, 0, 0);
    word("fj_begin", "begin ", 1, 0, 0, 0);
    word("fj_join",  "join ",  1, 0, 0, 0);
`endif

    do_reset();
    for (int i = 1; i <= TB_MAX; i++) word($sformatf("ovf_b%0d", i), "begin ", i, 0, 0, 0);
    word("overflow", "begin ", TB_MAX, 0, 1, 3);

    // Trailing word never fires; idle cycles carry a space that must be ignored.
    do_reset();
    for (int i = 0; i < tail.len(); i++) begin
      in_byte = tail[i]; in_valid = 1'b1; step();
      in_byte = 8'h20;   in_valid = 1'b0; step();
    end
    expect_state("no_trail", 0, 1, 0, 0);
    check_front();

    send_str("be");
    reset = 1'b1; in_valid = 1'b1; in_byte = "g";
    step();
    reset = 1'b0; in_valid = 1'b0;
    expect_state("mid_reset", 0, 1, 0, 0);
    check_front();
    word("reset_discard", "end ", 0, 0, 1, 1);

    do_reset();
    word("dbl_b",  "begin ", 1, 0, 0, 0);
    word("dbl_sp", " ",      1, 0, 0, 0);
    word("dbl_e",  "end ",   0, 1, 0, 0);

    checks++;
    assert (sb.size() == 0) else begin
      failures++; $error("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
